// File: rtl/msg_sched_pkg.sv
// Shared constants, FSM state type and sigma helpers for the 64-word message schedule.
// Word width 32, 16-word input block, 64-word output schedule.
package msg_sched_pkg;

  localparam int WORD_W    = 32;
  localparam int BLK_WORDS = 16;
  localparam int SCHED_LEN = 64;
  localparam int IDX_W     = 6;
  localparam int CNT_W     = 4;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/msg_sigma.sv
// Combinational sigma0/sigma1 pair used by the schedule recurrence.
// Zero latency; no flow control.
module msg_sigma
  import msg_sched_pkg::*;
(
  input  logic [WORD_W-1:0] x0,
  input  logic [WORD_W-1:0] x1,
  output logic [WORD_W-1:0] s0,
  output logic [WORD_W-1:0] s1
);

  assign s0 = sigma0(x0);
  assign s1 = sigma1(x1);

endmodule

// File: rtl/msg_sched.sv
// Message schedule: loads a 16-word block, then streams W[0..63] through a 16-word sliding window.
// One word per cycle in each phase; output stalls freeze the window, input is refused while emitting.
module msg_sched
  import msg_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SCHED_LEN - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  load_cnt;
  logic [IDX_W-1:0]  t;
  logic [WORD_W-1:0] win [BLK_WORDS];
  logic [WORD_W-1:0] s0, s1, w_new;
  logic              in_fire, out_fire;

  msg_sigma u_sigma (
    .x0 (win[1]),
    .x1 (win[14]),
    .s0 (s0),
    .s1 (s1)
  );

  assign w_new = s1 + win[9] + s0 + win[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && load_cnt == '1) state_nxt = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && t == LAST_IDX) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // load_cnt wraps to zero on the 16th word, which also clears it for the next block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt <= '0;
      t        <= '0;
      for (int i = 0; i < BLK_WORDS; i++) win[i] <= '0;
    end else begin
      if (in_fire) begin
        win[load_cnt] <= in_word;
        load_cnt      <= load_cnt + 1'b1;
        if (load_cnt == '1) t <= '0;
      end
      if (out_fire) begin
        for (int i = 0; i < BLK_WORDS - 1; i++) win[i] <= win[i+1];
        win[BLK_WORDS-1] <= w_new;
        t                <= t + 1'b1;
      end
    end
  end

  assign out_word = win[0];
  assign out_idx  = t;
  assign out_last = out_valid && (t == LAST_IDX);

endmodule

// File: tb/tb_msg_sched.sv
// Directed bench for msg_sched: abc block, stalls, all-ones wrap, resets in both phases.
module tb_msg_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic [5:0]  out_idx;
  logic        out_last;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] blk  [16];
  logic [31:0] wexp [64];
  logic [31:0] obs  [64];

  msg_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ms0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ms1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model();
    for (int i = 0; i < 16; i++) wexp[i] = blk[i];
    for (int i = 16; i < 64; i++)
      wexp[i] = ms1(wexp[i-2]) + wexp[i-7] + ms0(wexp[i-15]) + wexp[i-16];
  endtask

  task automatic load_block();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_word  = blk[i];
      chk("load_in_ready", 32'(in_ready), 32'd1);
      chk("load_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_word  = '0;
  endtask

  task automatic drain(input int stall_pct, input bit hold_in, input int n_words);
    int cnt = 0;
    int cyc = 0;
    bit go;
    while (cnt < n_words && cyc < 2000) begin
      out_ready = 1'b0;
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_idx", 32'(out_idx), 32'(cnt));
      chk("out_word", out_word, wexp[cnt]);
      chk("out_last", 32'(out_last), 32'(cnt == 63));
      obs[cnt] = out_word;
      if (hold_in) begin
        in_valid = 1'b1;
        in_word  = $urandom;
        chk("emit_in_ready", 32'(in_ready), 32'd0);
      end
      go = ($urandom_range(99) >= stall_pct);
      out_ready = go;
      @(posedge clk); #1;
      cyc++;
      if (go) cnt++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (cnt < n_words) chk("drain_timeout", 32'(cnt), 32'(n_words));
    if (n_words == 64) begin
      chk("post_in_ready", 32'(in_ready), 32'd1);
      chk("post_out_valid", 32'(out_valid), 32'd0);
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  initial begin
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // abc block, no stalls
    set_abc();
    build_model();
    load_block();
    drain(0, 1'b0, 64);
    chk("abc_w0", obs[0], 32'h61626380);
    chk("abc_w15", obs[15], 32'h00000018);
    chk("abc_w16", obs[16], 32'h61626380);
    chk("abc_w17", obs[17], 32'h000F0000);

    // abc block with 30% output stalls
    load_block();
    drain(30, 1'b0, 64);
    chk("stall_w17", obs[17], 32'h000F0000);

    // all-ones block with in_valid held high throughout emit
    for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
    build_model();
    load_block();
    drain(0, 1'b1, 64);
    chk("ones_w15", obs[15], 32'hFFFFFFFF);
    chk("ones_w16", obs[16], 32'h203FFFFC);

    // back-to-back block after the held-input emit
    for (int i = 0; i < 16; i++) blk[i] = 32'h01234567 * (i + 3);
    build_model();
    load_block();
    drain(10, 1'b0, 64);

    // reset after 9 input words
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_word  = 32'hDEAD0000 + i;
      chk("partial_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk("rst_load_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) blk[i] = 32'hA5000000 ^ (32'(i) << 4);
    build_model();
    load_block();
    drain(0, 1'b0, 64);
    chk("after_rst_w0", obs[0], 32'hA5000000);

    // reset at t = 30 while emitting
    set_abc();
    build_model();
    load_block();
    drain(0, 1'b0, 30);
    chk("pre_rst_idx", 32'(out_idx), 32'd30);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_emit_out_valid", 32'(out_valid), 32'd0);
    chk("rst_emit_out_last", 32'(out_last), 32'd0);
    chk("rst_emit_out_idx", 32'(out_idx), 32'd0);
    chk("rst_emit_out_word", out_word, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_emit_in_ready", 32'(in_ready), 32'd1);
    load_block();
    drain(0, 1'b0, 64);
    chk("recover_w17", obs[17], 32'h000F0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/msg_sched.md
MSG_SCHED -- requirements
Module: msg_sched

Interface
REQ-001 Parameters: none; word width 32, block length 16 words and schedule length 64 are fixed package constants.
REQ-002 CLK  input  1  single clock, all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 IN_VALID  input  1  IN_WORD carries a message word.
REQ-005 IN_READY  output  1  block accepts a message word this cycle.
REQ-006 IN_WORD  input  32  message word, big-endian word order M0..M15.
REQ-007 OUT_VALID  output  1  OUT_WORD carries schedule word W[OUT_IDX].
REQ-008 OUT_READY  input  1  consumer accepts the schedule word this cycle.
REQ-009 OUT_WORD  output  32  schedule word W[t].
REQ-010 OUT_IDX  output  6  index t, 0..63.
REQ-011 OUT_LAST  output  1  high together with OUT_VALID when t = 63.

Function
REQ-012 States SHALL be LOAD and EMIT only; the state after reset is LOAD.
REQ-013 Input handshake: a word is accepted on a rising edge where IN_VALID and IN_READY are both high.
REQ-014 Output handshake: a word is consumed on a rising edge where OUT_VALID and OUT_READY are both high.
REQ-015 LOAD: IN_READY = 1 and OUT_VALID = 0; each accepted word is written to window slot given by a 4-bit load counter, and the counter increments.
REQ-016 The 16th accepted word SHALL move the state to EMIT on the same edge, clear the load counter and set t = 0; there are no bubble cycles.
REQ-017 EMIT: IN_READY = 0, so IN_VALID is ignored; OUT_VALID = 1 and OUT_WORD = R[0], where R[0..15] holds W[t..t+15].
REQ-018 On each output handshake the window shifts so that R[i] <= R[i+1] for i = 0..14.
REQ-019 On the same handshake R[15] <= sigma1(R[14]) + R[9] + sigma0(R[1]) + R[0], modulo 2^32, with carries discarded; t increments.
REQ-020 sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
REQ-021 sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
REQ-022 Backpressure: while OUT_READY = 0, OUT_WORD, OUT_IDX, OUT_LAST and the window SHALL hold stable, with no limit on stall length.
REQ-023 The handshake at t = 63 returns the state to LOAD with IN_READY = 1 on the next cycle; the window contents are don't-care.
REQ-024 OUT_VALID SHALL NOT depend combinationally on OUT_READY, and IN_READY SHALL NOT depend combinationally on IN_VALID.
REQ-025 Throughput: 16 load cycles plus 64 emit cycles per block with no stalls.

Reset
REQ-026 Assertion of RST SHALL immediately force LOAD, load counter = 0, t = 0, IN_READY = 1 (0 while RST is high is also permitted), and OUT_VALID = OUT_LAST = 0.
REQ-027 Reset also sets OUT_IDX = 0, OUT_WORD = 0 and the window to zero.
REQ-028 A reset during LOAD or EMIT discards the partial block; the first accepted word after release is M0.

Structure
REQ-029 A shared package SHALL hold:
- word width 32, block words 16, schedule length 64;
- a state enum {LOAD, EMIT};
- the sigma0/sigma1 functions.
REQ-030 A combinational sub-module msg_sigma SHALL compute sigma0 and sigma1 of two inputs, so it can be tested on its own.

Verification
REQ-031 "abc" block, no stalls: load 0x61626380, 14 words of 0x00000000, then 0x00000018.
- Required: W0 = 0x61626380, W15 = 0x00000018, W16 = 0x61626380, W17 = 0x000F0000.
- Required: OUT_LAST high only at index 63.
REQ-032 Random stall pattern on OUT_READY (30%) with the same block: the W sequence SHALL match REQ-031 and a software model exactly, and outputs SHALL stay stable during each stall.
REQ-033 All-ones block (16 × 0xFFFFFFFF): W[0..15] = 0xFFFFFFFF; W16..W63 SHALL match the model, which checks mod-2^32 wrap-around.
REQ-034 Pulse RST after 9 input words:
- Required: OUT_VALID never rises.
- Required: a following complete block yields a W0 equal to its own first word.
REQ-035 Pulse RST at t = 30 during EMIT: OUT_VALID falls asynchronously and the state returns to LOAD.
REQ-036 Hold IN_VALID = 1 with changing IN_WORD throughout EMIT: no words are consumed, and the next block loads correctly back-to-back.
